// File: rtl/ddr3_ui_responder_if.sv
// ============================================================================
// Module      : ddr3_ui_if
// Description : DDR3 native UI (app_*) command, write-data and read-data
//               channels. The mask port exists only with
//               DDR3_UI_RESP_BYTE_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ddr3_ui_if;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
`ifdef DDR3_UI_RESP_BYTE_MASK_EN
    logic [15:0]  app_wdf_mask;
`endif
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         init_calib_complete;

    modport master (
`ifdef DDR3_UI_RESP_BYTE_MASK_EN
        output app_wdf_mask,
`endif
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete
    );

    modport slave (
`ifdef DDR3_UI_RESP_BYTE_MASK_EN
        input  app_wdf_mask,
`endif
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete
    );
endinterface

`default_nettype wire

// File: rtl/ddr3_ui_responder.sv
// ============================================================================
// Module      : ddr3_ui_responder
// Description : Block-RAM backed stand-in for the DDR3 MIG native UI with
//               LFSR-driven back-pressure. Optional byte masking is enabled
//               by defining DDR3_UI_RESP_BYTE_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_ui_responder #(
    parameter int MEM_AW      = 10,
    parameter int CMD_DEPTH   = 4,
    parameter int WDF_DEPTH   = 16,
    parameter int RD_LATENCY  = 8,
    parameter int INIT_CYCLES = 64
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ddr3_ui_if.slave         ui,
    input  wire logic        stall_en,
    input  wire logic [3:0]  stall_rate,
    output logic             protocol_err,
    output logic [15:0]      wr_count,
    output logic [15:0]      rd_count
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int WAW = $clog2(WDF_DEPTH);
    localparam int CLW = $clog2(INIT_CYCLES + 1);

    localparam logic [CAW:0]   c_cmd_depth  = (CAW+1)'(CMD_DEPTH);
    localparam logic [WAW:0]   c_wdf_depth  = (WAW+1)'(WDF_DEPTH);
    localparam logic [CLW-1:0] c_calib_last = CLW'(INIT_CYCLES - 1);

    localparam logic [0:0] S_CALIB      = 1'b0;
    localparam logic [0:0] S_RUN        = 1'b1;
    localparam logic [0:0] E_IDLE       = 1'b0;
    localparam logic [0:0] E_WAIT_WDATA = 1'b1;

    logic [0:0]     top_state_q;
    logic [CLW-1:0] calib_cnt_q;
    logic [15:0]    lfsr_q;
    logic           cmd_stall_q, wdf_stall_q;
    logic [0:0]     ex_state_q, ex_state_d;
    logic           protocol_err_q, protocol_err_d;
    logic [15:0]    wr_count_q, rd_count_q;

    // Command FIFO entry is {is_read, word index}; invalid opcodes never enter.
    logic [MEM_AW:0]  cmd_fifo_q [CMD_DEPTH];
    logic [CAW-1:0]   cmd_wr_ptr_q, cmd_rd_ptr_q;
    logic [CAW:0]     cmd_count_q, cmd_count_d;

    logic [127:0]     wdf_data_q [WDF_DEPTH];
`ifdef DDR3_UI_RESP_BYTE_MASK_EN
    logic [15:0]      wdf_mask_q [WDF_DEPTH];
`endif
    logic [WAW-1:0]   wdf_wr_ptr_q, wdf_rd_ptr_q;
    logic [WAW:0]     wdf_count_q, wdf_count_d;

    logic [127:0]     mem [2**MEM_AW];
    logic [127:0]     mem_rd_q;
    logic [RD_LATENCY-1:0] rd_vld_q;
    logic [127:0]     rd_pipe_q [1:RD_LATENCY-1];

    logic             run;
    logic             cmd_acc, cmd_push, cmd_pop, wdf_push, wdf_pop;
    logic             rd_issue, wr_issue;
    logic [MEM_AW:0]  cmd_head;
    logic             unused_addr_hi;

    assign run      = (top_state_q == S_RUN);
    assign ui.init_calib_complete = run;
    assign ui.app_rdy     = run & ~cmd_stall_q & (cmd_count_q < c_cmd_depth);
    assign ui.app_wdf_rdy = run & ~wdf_stall_q & (wdf_count_q < c_wdf_depth);

    assign cmd_acc  = ui.app_en & ui.app_rdy;
    assign cmd_push = cmd_acc & (ui.app_cmd[2:1] == 2'b00);
    assign wdf_push = ui.app_wdf_wren & ui.app_wdf_rdy;
    assign cmd_head = cmd_fifo_q[cmd_rd_ptr_q];

    // Writes pair with the oldest beat in either executor state; reads only issue from idle.
    assign rd_issue = (ex_state_q == E_IDLE) & (cmd_count_q != '0) & cmd_head[MEM_AW];
    assign wr_issue = (cmd_count_q != '0) & ~cmd_head[MEM_AW] & (wdf_count_q != '0);
    assign cmd_pop  = rd_issue | wr_issue;
    assign wdf_pop  = wr_issue;

    assign unused_addr_hi = ^ui.app_addr[27:MEM_AW+4];

    always_comb begin
        ex_state_d = ex_state_q;
        case (ex_state_q)
            E_IDLE:
                if ((cmd_count_q != '0) && !cmd_head[MEM_AW] && (wdf_count_q == '0))
                    ex_state_d = E_WAIT_WDATA;
            default:
                if (wdf_count_q != '0)
                    ex_state_d = E_IDLE;
        endcase
    end

    always_comb begin
        cmd_count_d    = cmd_count_q + (CAW+1)'(cmd_push) - (CAW+1)'(cmd_pop);
        wdf_count_d    = wdf_count_q + (WAW+1)'(wdf_push) - (WAW+1)'(wdf_pop);
        protocol_err_d = protocol_err_q
                       | (cmd_acc & (ui.app_cmd[2:1] != 2'b00))
                       | (cmd_acc & (ui.app_addr[3:0] != 4'h0))
                       | (ui.app_wdf_wren != ui.app_wdf_end)
                       | (~run & (ui.app_en | ui.app_wdf_wren));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_state_q    <= S_CALIB;
            calib_cnt_q    <= '0;
            lfsr_q         <= 16'hACE1;
            cmd_stall_q    <= 1'b0;
            wdf_stall_q    <= 1'b0;
            ex_state_q     <= E_IDLE;
            protocol_err_q <= 1'b0;
            wr_count_q     <= '0;
            rd_count_q     <= '0;
            cmd_wr_ptr_q   <= '0;
            cmd_rd_ptr_q   <= '0;
            cmd_count_q    <= '0;
            wdf_wr_ptr_q   <= '0;
            wdf_rd_ptr_q   <= '0;
            wdf_count_q    <= '0;
        end else begin
            if (top_state_q == S_CALIB) begin
                calib_cnt_q <= calib_cnt_q + CLW'(1);
                if (calib_cnt_q == c_calib_last)
                    top_state_q <= S_RUN;
            end else begin
                lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            end
            cmd_stall_q    <= stall_en & (lfsr_q[3:0] < stall_rate);
            wdf_stall_q    <= stall_en & (lfsr_q[7:4] < stall_rate);
            ex_state_q     <= ex_state_d;
            protocol_err_q <= protocol_err_d;
            wr_count_q     <= wr_count_q + 16'(wr_issue);
            rd_count_q     <= rd_count_q + 16'(rd_issue);
            cmd_count_q    <= cmd_count_d;
            wdf_count_q    <= wdf_count_d;
            if (cmd_push) cmd_wr_ptr_q <= cmd_wr_ptr_q + CAW'(1);
            if (cmd_pop)  cmd_rd_ptr_q <= cmd_rd_ptr_q + CAW'(1);
            if (wdf_push) wdf_wr_ptr_q <= wdf_wr_ptr_q + WAW'(1);
            if (wdf_pop)  wdf_rd_ptr_q <= wdf_rd_ptr_q + WAW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_fifo_q[cmd_wr_ptr_q] <= {ui.app_cmd[0], ui.app_addr[MEM_AW+3:4]};
        if (wdf_push) begin
            wdf_data_q[wdf_wr_ptr_q] <= ui.app_wdf_data;
`ifdef DDR3_UI_RESP_BYTE_MASK_EN
            wdf_mask_q[wdf_wr_ptr_q] <= ui.app_wdf_mask;
`endif
        end
    end

    // Storage array: no reset so it maps onto block RAM with byte enables.
    always_ff @(posedge clk) begin
        if (wr_issue && !rst) begin
`ifdef DDR3_UI_RESP_BYTE_MASK_EN
            for (int b = 0; b < 16; b++)
                if (!wdf_mask_q[wdf_rd_ptr_q][b])
                    mem[cmd_head[MEM_AW-1:0]][b*8 +: 8] <= wdf_data_q[wdf_rd_ptr_q][b*8 +: 8];
`else
            mem[cmd_head[MEM_AW-1:0]] <= wdf_data_q[wdf_rd_ptr_q];
`endif
        end
        if (rd_issue)
            mem_rd_q <= mem[cmd_head[MEM_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= '0;
            for (int j = 1; j < RD_LATENCY; j++)
                rd_pipe_q[j] <= '0;
        end else begin
            rd_vld_q     <= {rd_vld_q[RD_LATENCY-2:0], rd_issue};
            rd_pipe_q[1] <= mem_rd_q;
            for (int j = 2; j < RD_LATENCY; j++)
                rd_pipe_q[j] <= rd_pipe_q[j-1];
        end
    end

    assign ui.app_rd_data       = rd_pipe_q[RD_LATENCY-1];
    assign ui.app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
    assign protocol_err         = protocol_err_q;
    assign wr_count             = wr_count_q;
    assign rd_count             = rd_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr3_ui_responder.sv
// ============================================================================
// Module      : tb_ddr3_ui_responder
// Description : Self-checking bench for ddr3_ui_responder: calibration table,
//               directed sequences and a randomized stall run against an
//               in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr3_ui_responder;
    localparam int RD_LAT = 8;
    localparam int INIT   = 64;
    localparam int MAW    = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_en;
    logic [3:0]  stall_rate;
    logic        perr;
    logic [15:0] wrc, rdc;

    always #5 clk = ~clk;

    ddr3_ui_if ui();

    ddr3_ui_responder #(.MEM_AW(MAW), .CMD_DEPTH(4), .WDF_DEPTH(16),
                        .RD_LATENCY(RD_LAT), .INIT_CYCLES(INIT)) dut (
        .clk(clk), .rst(rst), .ui(ui), .stall_en(stall_en), .stall_rate(stall_rate),
        .protocol_err(perr), .wr_count(wrc), .rd_count(rdc)
    );

    int n_cmp = 0, n_fail = 0, cyc = 0;

    typedef struct { bit rd; logic [MAW-1:0] idx; } mcmd_t;
    typedef struct { logic [127:0] d; logic [15:0] m; } mbeat_t;
    logic [127:0] mmem [2**MAW];
    mcmd_t        mcmd_q[$];
    mbeat_t       mdat_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    int           got_cyc_q[$];

    always @(negedge clk)
        if (ui.app_rd_data_valid) begin
            got_q.push_back(ui.app_rd_data);
            got_cyc_q.push_back(cyc);
        end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1; cyc++;
    endtask

    // Reference model: commands complete strictly in order; a write completes once a beat exists.
    task automatic model_run();
        while (mcmd_q.size() > 0) begin
            if (mcmd_q[0].rd) begin
                exp_q.push_back(mmem[mcmd_q[0].idx]);
                void'(mcmd_q.pop_front());
            end else if (mdat_q.size() > 0) begin
`ifdef DDR3_UI_RESP_BYTE_MASK_EN
                for (int b = 0; b < 16; b++)
                    if (!mdat_q[0].m[b]) mmem[mcmd_q[0].idx][b*8 +: 8] = mdat_q[0].d[b*8 +: 8];
`else
                mmem[mcmd_q[0].idx] = mdat_q[0].d;
`endif
                void'(mcmd_q.pop_front());
                void'(mdat_q.pop_front());
            end else break;
        end
    endtask

    task automatic model_cmd(input logic [2:0] cmd, input logic [27:0] addr);
        mcmd_t c;
        if (cmd > 3'd1) return;
        c.rd = cmd[0]; c.idx = addr[MAW+3:4];
        mcmd_q.push_back(c);
        model_run();
    endtask

    task automatic model_beat(input logic [127:0] d, input logic [15:0] m);
        mbeat_t b;
        b.d = d; b.m = m;
        mdat_q.push_back(b);
        model_run();
    endtask

    task automatic idle_inputs();
        ui.app_en = 1'b0; ui.app_cmd = '0; ui.app_addr = '0;
        ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b0; ui.app_wdf_data = '0;
`ifdef DDR3_UI_RESP_BYTE_MASK_EN
        ui.app_wdf_mask = '0;
`endif
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        got_q.delete(); got_cyc_q.delete(); exp_q.delete();
        mcmd_q.delete(); mdat_q.delete();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_calib();
        while (cyc < INIT) step();
    endtask

    task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr, output int acc_cyc);
        bit ok = 1'b0;
        ui.app_en = 1'b1; ui.app_cmd = cmd; ui.app_addr = addr;
        acc_cyc = -1;
        for (int t = 0; t < 500 && !ok; t++) begin
            ok = ui.app_rdy;
            acc_cyc = cyc;
            step();
        end
        ui.app_en = 1'b0;
        chk("cmd_accept", ok, 1);
        if (ok) model_cmd(cmd, addr);
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [15:0] m);
        bit ok = 1'b0;
        ui.app_wdf_wren = 1'b1; ui.app_wdf_end = 1'b1; ui.app_wdf_data = d;
`ifdef DDR3_UI_RESP_BYTE_MASK_EN
        ui.app_wdf_mask = m;
`endif
        for (int t = 0; t < 500 && !ok; t++) begin
            ok = ui.app_wdf_rdy;
            step();
        end
        ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b0;
        chk("beat_accept", ok, 1);
        if (ok) model_beat(d, m);
    endtask

    task automatic drain(input string name, output logic [127:0] last, output int first_cyc);
        int n = exp_q.size();
        for (int t = 0; t < 3000 && got_q.size() < n; t++) step();
        repeat (RD_LAT + 4) step();
        chk({name, "_count"}, 128'(got_q.size()), 128'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) chk(name, got_q[i], exp_q[i]);
        last      = (got_q.size() > 0) ? got_q[got_q.size()-1] : '0;
        first_cyc = (got_cyc_q.size() > 0) ? got_cyc_q[0] : -1;
        got_q.delete(); got_cyc_q.delete(); exp_q.delete();
    endtask

    typedef struct {
        int cyc; bit rst_first; bit en;
        bit exp_init; bit exp_rdy; bit exp_perr;
    } vec_t;
    vec_t tbl[9];

    initial begin
        logic [127:0] last, v[5];
        int acc, first_acc, first_vld, stall_seen;

        stall_en = 1'b0; stall_rate = 4'd0;
        idle_inputs();

        // Calibration window and command-during-calibration error.
        tbl[0] = '{0,  1, 0, 0, 0, 0};
        tbl[1] = '{1,  0, 0, 0, 0, 0};
        tbl[2] = '{40, 0, 0, 0, 0, 0};
        tbl[3] = '{63, 0, 0, 0, 0, 0};
        tbl[4] = '{64, 0, 0, 1, 1, 0};
        tbl[5] = '{66, 0, 0, 1, 1, 0};
        tbl[6] = '{5,  1, 1, 0, 0, 0};
        tbl[7] = '{6,  0, 0, 0, 0, 1};
        tbl[8] = '{64, 0, 0, 1, 1, 1};
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst_first) reset_dut();
            while (cyc < tbl[i].cyc) step();
            chk($sformatf("calib_init_c%0d", tbl[i].cyc), ui.init_calib_complete, tbl[i].exp_init);
            chk($sformatf("calib_rdy_c%0d", tbl[i].cyc), ui.app_rdy, tbl[i].exp_rdy);
            chk($sformatf("calib_wrdy_c%0d", tbl[i].cyc), ui.app_wdf_rdy, tbl[i].exp_rdy);
            chk($sformatf("calib_perr_c%0d", tbl[i].cyc), perr, tbl[i].exp_perr);
            chk("calib_vld", ui.app_rd_data_valid, 0);
            ui.app_en = tbl[i].en;
        end
        ui.app_en = 1'b0;

        // Four beats, four writes, four reads with minimum latency.
        reset_dut(); wait_calib();
        for (int i = 0; i < 4; i++) send_beat({32{4'(i)}}, 16'h0);
        for (int i = 0; i < 4; i++) send_cmd(3'd0, 28'(16*i), acc);
        for (int i = 0; i < 4; i++) begin
            send_cmd(3'd1, 28'(16*i), acc);
            if (i == 0) first_acc = acc;
        end
        drain("basic_rd", last, first_vld);
        chk("basic_latency", 128'(first_vld - first_acc), 128'(RD_LAT + 1));
        chk("basic_wrc", wrc, 16'd4);
        chk("basic_rdc", rdc, 16'd4);

        // Commands ahead of data fill the command FIFO.
        reset_dut(); wait_calib();
        for (int i = 0; i < 5; i++) v[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) send_cmd(3'd0, 28'(16*(400+i)), acc);
        step(); step();
        chk("full_rdy", ui.app_rdy, 0);
        chk("full_wrc", wrc, 16'd0);
        send_beat(v[0], 16'h0);
        send_cmd(3'd0, 28'(16*404), acc);
        for (int i = 1; i < 5; i++) send_beat(v[i], 16'h0);
        for (int i = 0; i < 5; i++) send_cmd(3'd1, 28'(16*(400+i)), acc);
        drain("full_rd", last, first_vld);
        chk("full_wrc5", wrc, 16'd5);
        chk("full_rdc5", rdc, 16'd5);

        // Randomized traffic under back-pressure: write page at word 64, random reads, read page.
        reset_dut();
        stall_en = 1'b1; stall_rate = 4'd8;
        wait_calib();
        begin
            int wr_sent = 0, bt_sent = 0, rd_page = 0;
            bit done = 1'b0, acc_c, acc_b;
            stall_seen = 0;
            for (int t = 0; t < 30000 && !done; t++) begin
                if (!ui.app_en && $urandom_range(3) != 0) begin
                    if (wr_sent < 256 && ($urandom_range(3) != 0 || wr_sent == 0)) begin
                        ui.app_en = 1'b1; ui.app_cmd = 3'd0; ui.app_addr = 28'(16*(64+wr_sent));
                        wr_sent++;
                    end else if (wr_sent < 256) begin
                        ui.app_en = 1'b1; ui.app_cmd = 3'd1;
                        ui.app_addr = 28'(16*(64 + $urandom_range(wr_sent-1)));
                    end else if (rd_page < 256) begin
                        ui.app_en = 1'b1; ui.app_cmd = 3'd1; ui.app_addr = 28'(16*(64+rd_page));
                        rd_page++;
                    end
                end
                if (!ui.app_wdf_wren && bt_sent < 256 && $urandom_range(3) != 0) begin
                    ui.app_wdf_wren = 1'b1; ui.app_wdf_end = 1'b1;
                    ui.app_wdf_data = {$urandom, $urandom, $urandom, $urandom};
                    bt_sent++;
                end
                acc_c = ui.app_en & ui.app_rdy;
                acc_b = ui.app_wdf_wren & ui.app_wdf_rdy;
                if (ui.app_wdf_wren && !ui.app_wdf_rdy) stall_seen++;
                step();
                if (acc_c) begin
                    model_cmd(ui.app_cmd, ui.app_addr);
                    ui.app_en = 1'b0;
                end
                if (acc_b) begin
                    model_beat(ui.app_wdf_data, 16'h0);
                    ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b0;
                end
                done = (rd_page == 256) && (bt_sent == 256) && !ui.app_en && !ui.app_wdf_wren;
            end
            chk("rand_done", done, 1);
        end
        drain("rand_rd", last, first_vld);
        chk("rand_wrc", wrc, 16'd256);
        chk("rand_perr", perr, 0);
        chk("rand_stall_seen", stall_seen > 0, 1);
        stall_en = 1'b0; stall_rate = 4'd0;

        // Misaligned read and an invalid opcode.
        reset_dut(); wait_calib();
        send_cmd(3'd1, 28'h4, acc);
        chk("perr_misalign", perr, 1);
        send_cmd(3'd3, 28'h20, acc);
        repeat (20) step();
        chk("perr_held", perr, 1);
        chk("perr_rdc", rdc, 16'd1);
        drain("perr_rd", last, first_vld);
        reset_dut();
        chk("perr_cleared", perr, 0);
        wait_calib();
        chk("perr_clean_run", perr, 0);
        ui.app_wdf_end = 1'b1;
        step();
        ui.app_wdf_end = 1'b0;
        chk("perr_wdf_end", perr, 1);

        // Reset with a read in flight discards it.
        reset_dut(); wait_calib();
        send_cmd(3'd1, 28'h0, acc);
        step(); step();
        reset_dut();
        repeat (RD_LAT + 10) step();
        chk("rst_flush", 128'(got_q.size()), 0);

        // Masked overwrite.
        reset_dut(); wait_calib();
        send_beat({128{1'b1}}, 16'h0);
        send_cmd(3'd0, 28'(16*500), acc);
        send_beat('0, 16'h00FF);
        send_cmd(3'd0, 28'(16*500), acc);
        send_cmd(3'd1, 28'(16*500), acc);
        drain("mask_rd", last, first_vld);
`ifdef DDR3_UI_RESP_BYTE_MASK_EN
        chk("mask_value", last, 128'h0000000000000000FFFFFFFFFFFFFFFF);
`else
        chk("mask_value", last, 128'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ddr3_ui_responder.md
Name: ddr3_ui_responder

Overview:
- Synthesizable stand-in for the DDR3 memory-interface native UI (app_* command, write-data and read-data channels), backed by on-chip block RAM.
- Sits on the far side of the page transfer controller in its place of the MIG core. It lets the page-transfer path be brought up and stress-tested in simulation and on hardware without external DDR3.
- Injects pseudo-random back-pressure on app_rdy and app_wdf_rdy so the controller's stall and hold paths are exercised.

Parameters:
- MEM_AW, 10: log2 of memory depth in 128-bit words (1024 words, 4 pages).
- CMD_DEPTH, 4: command FIFO depth (power of 2).
- WDF_DEPTH, 16: write-data FIFO depth (power of 2).
- RD_LATENCY, 8: cycles from command pop to app_rd_data_valid; must be >= 2.
- INIT_CYCLES, 64: cycles after reset before init_calib_complete rises.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, synchronous, active-high.
- app_addr  in  28  UI byte-lane address, 16 per 128-bit beat.
- app_cmd  in  3  0 = write, 1 = read.
- app_en  in  1  command valid.
- app_rdy  out  1  command accepted this cycle when app_en is also high.
- app_wdf_data  in  128  write data.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat of burst; must equal app_wdf_wren.
- app_wdf_rdy  out  1  write beat accepted this cycle when app_wdf_wren is also high.
- app_rd_data  out  128  read data.
- app_rd_data_valid  out  1  read data strobe.
- init_calib_complete  out  1  UI ready.
- stall_en  in  1  enable back-pressure injection.
- stall_rate  in  4  stall probability, in sixteenths.
- protocol_err  out  1  sticky protocol-violation flag.
- wr_count  out  16  write commands executed, wrapping.
- rd_count  out  16  read commands executed, wrapping.

Behaviour:
- Reset values: all outputs 0. FIFOs, read pipeline, counters and the calibration counter are cleared. The LFSR loads 16'hACE1. RAM contents are not cleared.
- A reset mid-operation discards all queued commands, queued data and in-flight reads; no app_rd_data_valid pulses after rst.
- Top FSM:
  - S_CALIB: count INIT_CYCLES cycles. app_rdy and app_wdf_rdy are held 0.
  - S_RUN: init_calib_complete = 1. Remain here until rst.
- Ready signals are combinational from registered state only; they never depend on app_en or app_wdf_wren.
  - app_rdy = run & !cmd_stall_q & (cmd_count < CMD_DEPTH).
  - app_wdf_rdy = run & !wdf_stall_q & (wdf_count < WDF_DEPTH).
- Stall generation:
  - The 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle in S_RUN.
  - cmd_stall_q <= stall_en & (lfsr[3:0] < stall_rate).
  - wdf_stall_q <= stall_en & (lfsr[7:4] < stall_rate).
  - stall_rate 0 means no stalls.
- Accepts:
  - A command is accepted when app_en & app_rdy. It pushes {cmd, app_addr[MEM_AW+3:4]}.
  - A write beat is accepted when app_wdf_wren & app_wdf_rdy. It pushes the data.
  - A simultaneous push and pop on a FIFO leaves its count unchanged.
- Word index uses app_addr[MEM_AW+3:4]. Upper address bits are ignored, so addresses alias modulo the memory size.
- Write data may arrive before or after its command; beats pair with write commands strictly in order.
- Executor, one pop per cycle, in order:
  - E_IDLE: if the command FIFO is non-empty:
    - read: pop, issue the RAM read, launch the RD_LATENCY pipeline, rd_count++.
    - write with the write-data FIFO non-empty: pop both, write RAM, wr_count++.
    - write with the write-data FIFO empty: go to E_WAIT_WDATA without popping.
  - E_WAIT_WDATA: when the write-data FIFO becomes non-empty, pop both, write RAM, return to E_IDLE.
- Read data:
  - app_rd_data_valid pulses 1 cycle per read, exactly RD_LATENCY cycles after the pop.
  - Minimum latency is RD_LATENCY + 1 cycles from accept to valid.
  - Reads return in command order.
  - A read after a write to the same word returns the new data.
  - No back-pressure on read data.
- protocol_err is set, and held until rst, on any of:
  - an accepted command with app_cmd not 0 or 1; that command is dropped.
  - an accepted command with app_addr[3:0] != 0; the command still executes using the truncated index.
  - app_wdf_wren != app_wdf_end in any cycle.
  - app_en or app_wdf_wren high while in S_CALIB.
- wr_count and rd_count wrap 16'hFFFF -> 0.

Optional Feature:
- Macro: DDR3_UI_RESP_BYTE_MASK_EN.
- Defined:
  - Adds input app_wdf_mask[15:0], stored alongside the data in the write-data FIFO.
  - A mask bit of 1 leaves the corresponding byte of the RAM word unchanged; the RAM uses per-byte write enables.
- Undefined:
  - No mask port.
  - Every write replaces all 16 bytes.

Test Plan:
- Reset, then idle with stall_en=0 -> init_calib_complete rises at cycle 64; app_rdy and app_wdf_rdy are 0 before it. A command asserted during calibration sets protocol_err.
- 4 write beats 128'h0..0, 128'h1..1, 128'h2..2, 128'h3..3, then writes to addr 0,16,32,48, then reads of the same addresses -> 4 valid pulses in order with matching data; first valid exactly RD_LATENCY+1 cycles after the first read accept. wr_count=4, rd_count=4.
- 5 write commands with no write data -> app_rdy drops after the 4th accept (CMD_DEPTH=4) and the executor sits in E_WAIT_WDATA. Supply 5 beats -> all drain, wr_count=5, and reads return the 5 values.
- stall_en=1, stall_rate=8, with the page transfer controller doing a 256-beat write page then a read page at address 0x400 -> pg_ack for both pages, zero data mismatches, and cycles with app_wdf_rdy=0 while app_wdf_wren=1 are observed.
- A read at addr 0x04 and a command with app_cmd=3 -> protocol_err=1 and held; rd_count=1 (the cmd-3 command is dropped). rst clears the flag.
- With DDR3_UI_RESP_BYTE_MASK_EN: write all 0xFF, then write 0x00 with mask 16'h00FF -> read returns 0x0000000000000000FFFFFFFFFFFFFFFF. Without the macro, the same sequence (no mask) reads all 0x00.
